// File: rtl/ucc_pkg.sv
// Shared definitions for the bit-serial ALU: mode codes, FSM states, default width.
package ucc_pkg;

  localparam int UCC_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_AND = 2'b10,
    MODE_OR  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Majority of three bits, i.e. the carry out of a full adder.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ucc_serial_cell.sv
// One bit slice of the ALU chain. The serial top reuses it once per bit,
// feeding the carry back through a register.
module ucc_serial_cell
  import ucc_pkg::*;
(
  input  logic       c,
  input  logic       f,
  input  logic       p,
  input  logic [1:0] m,
  output logic       s,
  output logic       co
);

  // Logic modes pass the carry through untouched so it survives the whole word.
  always_comb begin
    s  = 1'b0;
    co = c;
    case (mode_e'(m))
      MODE_ADD: begin
        s  = f ^ p ^ c;
        co = maj3(f, p, c);
      end
      MODE_SUB: begin
        s  = f ^ ~p ^ c;
        co = maj3(f, ~p, c);
      end
      MODE_AND: begin
        s  = f & p;
        co = c;
      end
      MODE_OR: begin
        s  = f | p;
        co = c;
      end
      default: begin
        s  = 1'b0;
        co = c;
      end
    endcase
  end

endmodule

// File: rtl/ucc_serial8.sv
// Bit-serial ALU: operands are shifted LSB first through a single cell over
// WIDTH cycles. The result is assembled internally and published only when
// the operation completes, so fout never shows partial values.
module ucc_serial8
  import ucc_pkg::*;
#(
  parameter int WIDTH = UCC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cin,
  input  logic [WIDTH-1:0] fin,
  input  logic [WIDTH-1:0] pin,
  input  logic [1:0]       m,
  output logic             busy,
  output logic             done,
  output logic             cout,
  output logic [WIDTH-1:0] fout,
  output logic [1:0]       mout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_f;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_fout;
  logic [1:0]       r_mode;
  logic [1:0]       r_mout;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_accNext;

  ucc_serial_cell u_cell (
    .c  (r_carry),
    .f  (r_f[0]),
    .p  (r_p[0]),
    .m  (r_mode),
    .s  (w_s),
    .co (w_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  assign w_accNext = WIDTH'({w_s, r_acc} >> 1);

  assign busy = r_busy;
  assign done = r_done;
  assign cout = r_cout;
  assign fout = r_fout;
  assign mout = r_mout;

  // Control FSM with operand shifters, carry/mode registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_f     <= '0;
      r_p     <= '0;
      r_acc   <= '0;
      r_fout  <= '0;
      r_mode  <= 2'b00;
      r_mout  <= 2'b00;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_f     <= fin;
            r_p     <= pin;
            r_carry <= cin;
            r_mode  <= m;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_f     <= r_f >> 1;
          r_p     <= r_p >> 1;
          r_carry <= w_c;
          r_acc   <= w_accNext;
          if (r_cnt == LAST_BIT) begin
            r_cnt   <= '0;
            r_fout  <= w_accNext;
            r_cout  <= w_c;
            r_mout  <= r_mode;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
